ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 131 +++++++++++++
 tb/tb_ps2_host_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-bit frame, ack check, timeout).
// Ports: clk/reset_n (async active-low); tx_data/tx_valid/tx_ready byte request handshake;
//        ps2clk_in/ps2data_in raw line levels; ps2clk_oe/ps2data_oe open-drain pull-low enables;
//        tx_done one-cycle completion pulse with tx_ack_ok/tx_error held until the next tx_done.
module ps2_host_tx #(
    parameter int C_inhibit_cycles = 2500,
    parameter int C_timeout_cycles = 375000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error
);
    localparam int IW = C_inhibit_cycles > 1 ? $clog2(C_inhibit_cycles) : 1;
    localparam int TW = C_timeout_cycles > 1 ? $clog2(C_timeout_cycles) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(C_inhibit_cycles - 1);
    localparam logic [IW-1:0] INH_PREV = IW'(C_inhibit_cycles - 2);
    localparam logic [TW-1:0] TO_LAST = TW'(C_timeout_cycles - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, RELEASE} state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    edge_cnt;
    logic [8:0]    shreg;
    logic          ack;

    assign fall = clk_prev & ~clk_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_prev   <= 1'b1;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            edge_cnt   <= '0;
            shreg      <= '0;
            ack        <= 1'b0;
            tx_ready   <= 1'b1;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_ack_ok  <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2clk_in};
            data_sync <= {data_sync[0], ps2data_in};
            clk_prev  <= clk_sync[1];
            tx_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        // parity bit sits above the data so the frame shifts out as one word
                        shreg      <= {~^tx_data, tx_data};
                        inh_cnt    <= '0;
                        ps2clk_oe  <= 1'b1;
                        ps2data_oe <= C_inhibit_cycles == 1;
                        tx_ready   <= 1'b0;
                        state      <= INHIBIT;
                    end else begin
                        // re-armed one cycle after returning so tx_ready stays low through tx_done
                        tx_ready <= 1'b1;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2clk_oe  <= 1'b0;
                        ps2data_oe <= 1'b1;
                        to_cnt     <= '0;
                        state      <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                        if (C_inhibit_cycles > 1 && inh_cnt == INH_PREV) ps2data_oe <= 1'b1;
                    end
                end
                RTS: begin
                    edge_cnt <= '0;
                    to_cnt   <= to_cnt + 1'b1;
                    state    <= SHIFT;
                end
                default: begin
                    // timeout is checked first so it wins over a coincident ack edge
                    if (to_cnt >= TO_LAST) begin
                        ps2clk_oe  <= 1'b0;
                        ps2data_oe <= 1'b0;
                        tx_done    <= 1'b1;
                        tx_ack_ok  <= 1'b0;
                        tx_error   <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (state == SHIFT && fall) begin
                            edge_cnt <= edge_cnt + 1'b1;
                            if (edge_cnt == 4'd9) begin
                                ps2data_oe <= 1'b0;
                                state      <= ACK;
                            end else begin
                                ps2data_oe <= ~shreg[0];
                                shreg      <= {1'b0, shreg[8:1]};
                            end
                        end else if (state == ACK && fall) begin
                            edge_cnt <= edge_cnt + 1'b1;
                            ack      <= ~data_sync[1];
                            state    <= RELEASE;
                        end else if (state == RELEASE && clk_sync[1] && data_sync[1]) begin
                            tx_done   <= 1'b1;
                            tx_ack_ok <= ack;
                            tx_error  <= ~ack;
                            state     <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx against a behavioural PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH = 8;
    localparam int TO = 200;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2clk_oe, ps2data_oe, tx_done, tx_ack_ok, tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2clk, ps2data;

    assign ps2clk = ~(ps2clk_oe | dev_clk_low);
    assign ps2data = ~(ps2data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.C_inhibit_cycles(INH), .C_timeout_cycles(TO)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2clk_in(ps2clk), .ps2data_in(ps2data), .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe),
        .tx_done(tx_done), .tx_ack_ok(tx_ack_ok), .tx_error(tx_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int run = 0, dhi = 0, inh_len = 0, inh_dhi = 0, inh_starts = 0;
    int dones = 0, accepts = 0, ready_viol = 0;
    bit busy = 0, after_done = 0, inh_last = 0, done_ack = 0, done_err = 0;

    always begin
        @(negedge clk);
        #2;
        if (!reset_n) begin
            busy = 0;
            after_done = 0;
            run = 0;
            dhi = 0;
        end else begin
            if (ps2clk_oe) begin
                if (run == 0) inh_starts++;
                run++;
                if (ps2data_oe) dhi++;
                inh_last = ps2data_oe;
            end else if (run > 0) begin
                inh_len = run;
                inh_dhi = dhi;
                run = 0;
                dhi = 0;
            end
            if (after_done && !tx_ready) ready_viol++;
            if (busy && tx_ready) ready_viol++;
            after_done = 0;
            if (tx_done) begin
                dones++;
                done_ack = tx_ack_ok;
                done_err = tx_error;
                busy = 0;
                after_done = 1;
            end
            if (tx_valid && tx_ready) begin
                accepts++;
                busy = 1;
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit hold);
        int w = 0;
        while (!tx_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = hold;
        tx_data = 8'($urandom);
    endtask

    // Device side: waits for request-to-send, clocks nedges falling edges and records
    // the line just before edges 2..11 (data LSB first, parity, stop).
    task automatic dev_run(input int nedges, input bit ack, output logic [9:0] bits);
        int w = 0;
        bits = '0;
        while (!ps2clk_oe && w < 50) begin
            @(negedge clk);
            w++;
        end
        while (ps2clk_oe && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rts_seen", w < 100, 1);
        check("start_bit", ps2data, 0);
        repeat (4) @(negedge clk);
        for (int k = 1; k <= nedges; k++) begin
            if (k >= 2) bits[k-2] = ps2data;
            if (k == 11) begin
                dev_data_low = ack;
                @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int n);
        int w = 0;
        while (dones < d0 + n && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("done_count", dones - d0, n);
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack);
        logic [9:0] bits;
        int d0 = dones;
        send(d, 0);
        dev_run(11, ack, bits);
        wait_done(d0, 1);
        check("byte", bits[7:0], d);
        check("parity", bits[8], ($countones(d) % 2) == 0);
        check("stop", bits[9], 1);
        check("inh_len", inh_len, INH);
        check("inh_data_cycles", inh_dhi, 1);
        check("inh_data_last", inh_last, 1);
        check("ack_ok", done_ack, ack);
        check("error", done_err, !ack);
    endtask

    initial begin
        logic [9:0] bits;
        int d0, a0, s0, w;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] bits;
        logic [7:0] d;
        int d0, a0, s0, w;
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_clk_oe", ps2clk_oe, 0);
        check("rst_data_oe", ps2data_oe, 0);
        check("rst_done", tx_done, 0);
        check("rst_ack_ok", tx_ack_ok, 0);
        check("rst_error", tx_error, 0);
        #3 reset_n = 1'b1;
        @(negedge clk);

        xfer(8'hED, 1);
        xfer(8'h00, 1);
        xfer(8'hFF, 1);
        xfer(8'h55, 0);

        // falling edges while idle must be ignored
        repeat (3) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        check("idle_edges_oe", {ps2clk_oe, ps2data_oe}, 0);
        check("idle_edges_ready", tx_ready, 1);

        repeat (6) begin
            d = 8'($urandom);
            xfer(d, $urandom_range(0, 2) != 0);
        end

        // tx_valid held high across two transfers
        d0 = dones;
        a0 = accepts;
        s0 = inh_starts;
        send(8'h3C, 1);
        dev_run(11, 1, bits);
        check("hold1_byte", bits[7:0], 8'h3C);
        wait_done(d0, 1);
        w = 0;
        while (accepts < a0 + 2 && w < 20) begin
            @(negedge clk);
            w++;
        end
        tx_valid = 1'b0;
        dev_run(11, 1, bits);
        wait_done(d0, 2);
        repeat (20) @(negedge clk);
        check("hold_accepts", accepts - a0, 2);
        check("hold_inhibits", inh_starts - s0, 2);
        check("hold_ready_window", ready_viol, 0);

        // no device clock: timeout exactly TO cycles after request-to-send
        send(8'hA5, 0);
        w = 0;
        while (!ps2clk_oe && w < 50) begin
            @(negedge clk);
            w++;
        end
        while (ps2clk_oe && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("to_rts_seen", w < 100, 1);
        repeat (TO - 1) @(negedge clk);
        check("to_pre_data_oe", ps2data_oe, 1);
        check("to_pre_done", tx_done, 0);
        @(negedge clk);
        check("to_oe", {ps2clk_oe, ps2data_oe}, 0);
        check("to_done", tx_done, 1);
        check("to_error", tx_error, 1);
        check("to_ack_ok", tx_ack_ok, 0);
        repeat (5) @(negedge clk);
        check("to_error_hold", tx_error, 1);

        // reset after edge 4, then a clean send
        d0 = dones;
        send(8'h00, 0);
        dev_run(4, 1, bits);
        check("pre_rst_data_oe", ps2data_oe, 1);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_oe", {ps2clk_oe, ps2data_oe}, 0);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_done", tx_done, 0);
        repeat (3) @(negedge clk);
        #3 reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_done", dones - d0, 0);
        xfer(8'hF4, 1);
        check("final_ready_window", ready_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
